qdec_syntax_ring: RTL

- Parametrised N-bank rotating syntax buffer. It is the successor to the two-bank ping-pong CTU line buffer.
- The CABAC context FSM writes decoded CTU syntax into the current write bank and commits it with a per-CTU pulse.
- Downstream modules read committed banks in order and release them explicitly.
- Bank depth, data width and bank count are all parameters. Writer/reader backpressure and error flagging are added.

---
 rtl/qdec_syntax_ring.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/qdec_syntax_ring.sv
// rtl/qdec_syntax_ring.sv - N-bank rotating CTU syntax buffer (optional macro QDEC_SYNTAX_RING_RLEN_EN)
module qdec_syntax_ring #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 12,
  parameter int NUM_BANKS = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               lb_we,
  input  logic [ADDR_W-1:0]                  lb_waddr,
  input  logic [DATA_W-1:0]                  lb_din,
  input  logic                               lb_wdone,
  output logic                               lb_wrdy,
  input  logic                               lb_re,
  input  logic [ADDR_W-1:0]                  lb_raddr,
  output logic [DATA_W-1:0]                  lb_dout,
  output logic                               lb_rvld,
  input  logic                               lb_rdone,
  output logic [$clog2(NUM_BANKS+1)-1:0]     lb_level,
  output logic [ADDR_W:0]                    lb_rlen,
  output logic                               lb_err
);

  localparam int PTR_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int LVL_W = $clog2(NUM_BANKS + 1);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int MEM_W = PTR_W + ADDR_W;

  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(NUM_BANKS - 1);
  localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(NUM_BANKS);
  localparam logic [LVL_W-1:0] NEAR_FULL = LVL_W'(NUM_BANKS - 1);

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic [DATA_W-1:0] r_dout;
  logic              r_err;

  logic [DATA_W-1:0] r_mem [NUM_BANKS*DEPTH];

  logic              w_wrdy;
  logic              w_rvld;
  logic              w_wr_ok;
  logic              w_commit;
  logic              w_rd_ok;
  logic              w_release;
  logic              w_proto_err;
  logic [PTR_W-1:0]  w_wr_next;
  logic [PTR_W-1:0]  w_rd_next;
  logic [MEM_W-1:0]  w_wphys;
  logic [MEM_W-1:0]  w_rphys;

  // Ownership flags come straight from the registered level; no same-cycle bypass.
  assign w_wrdy = (r_level < FULL_LVL);
  assign w_rvld = (r_level != '0);

  assign w_wr_ok   = lb_we    & w_wrdy;
  assign w_commit  = lb_wdone & w_wrdy;
  assign w_rd_ok   = lb_re    & w_rvld;
  assign w_release = lb_rdone & w_rvld;

  assign w_proto_err = ((lb_we | lb_wdone) & ~w_wrdy) |
                       ((lb_re | lb_rdone) & ~w_rvld);

  // Pointers wrap at NUM_BANKS, which need not be a power of two.
  assign w_wr_next = (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
  assign w_rd_next = (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;

  // Bank depth is a power of two, so bank*DEPTH + addr is a plain concatenation.
  assign w_wphys = {r_wr_ptr, lb_waddr};
  assign w_rphys = {r_rd_ptr, lb_raddr};

  assign lb_wrdy  = w_wrdy;
  assign lb_rvld  = w_rvld;
  assign lb_level = r_level;
  assign lb_dout  = r_dout;
  assign lb_err   = r_err;

  // Syntax RAM write port; contents survive reset and are simply overwritten.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[w_wphys] <= lb_din;
    end
  end

  // Registered read port; data holds when no valid read is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout <= '0;
    end else if (w_rd_ok) begin
      r_dout <= r_mem[w_rphys];
    end
  end

  // Write pointer advances on every accepted commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
    end else if (w_commit) begin
      r_wr_ptr <= w_wr_next;
    end
  end

  // Read pointer advances on every accepted release; a same-cycle read used the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
    end else if (w_release) begin
      r_rd_ptr <= w_rd_next;
    end
  end

  // Level counts committed, unreleased banks; commit plus release cancels out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level <= '0;
    end else begin
      case ({w_commit, w_release})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Sticky protocol-error flag; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_proto_err) begin
      r_err <= 1'b1;
    end
  end

`ifdef QDEC_SYNTAX_RING_RLEN_EN
  logic [ADDR_W:0] r_len [NUM_BANKS];
  logic [ADDR_W:0] w_wlen_cand;

  assign w_wlen_cand = {1'b0, lb_waddr} + 1'b1;
  assign lb_rlen     = r_len[r_rd_ptr];

  // Per-bank high-water mark. A bank's length clears when it becomes writable:
  // at commit when a free bank follows, or at release when the ring was full
  // (then the released bank is the one the writer gets next).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        r_len[i] <= '0;
      end
    end else begin
      if (w_wr_ok && (w_wlen_cand > r_len[r_wr_ptr])) begin
        r_len[r_wr_ptr] <= w_wlen_cand;
      end
      if (w_commit && !((r_level == NEAR_FULL) && !w_release)) begin
        r_len[w_wr_next] <= '0;
      end
      if (w_release && (r_level == FULL_LVL)) begin
        r_len[r_rd_ptr] <= '0;
      end
    end
  end
`else
  assign lb_rlen = '0;
`endif

endmodule
